// File: rtl/pmodi2s_tx_fifo.sv
// I2S / left-justified master transmitter for the Pmod I2S DAC: generates mclk/sck/lrck
// and serialises stereo frames popped from an internal FIFO once per lrck frame.
module pmodi2s_tx_fifo #(
    parameter int DATA_W     = 24,
    parameter int SLOT_W     = 32,
    parameter int MCLK_DIV   = 4,
    parameter int SCK_RATIO  = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int LJ_MODE    = 0,
    parameter int HOLD_LAST  = 0
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            en_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [DATA_W-1:0]               in_left_i,
    input  logic [DATA_W-1:0]               in_right_i,
    output logic                            data_rd_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level_o,
    output logic                            underrun_o,
    output logic [15:0]                     underrun_cnt_o,
    input  logic                            clr_underrun_i,
    output logic                            mclk_o,
    output logic                            sck_o,
    output logic                            lrck_o,
    output logic                            sdin_o
);
    localparam int D  = MCLK_DIV * SCK_RATIO;
    localparam int F  = 2 * SLOT_W * D;
    localparam int CW = $clog2(F);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int FW = 2 * DATA_W;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic [FW-1:0]   mem [FIFO_DEPTH];
    logic [FW-1:0]   head;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            in_ready_q, in_ready_d;
    logic            data_rd_q;
    logic            underrun_q, underrun_d;
    logic [15:0]     ucnt_q, ucnt_d;
    logic            mclk_q, mclk_d, sck_q, sck_d, lrck_q, lrck_d, sdin_q, sdin_d;
    logic            load, push, pop, underrun_ev;
    int              c, b;

    // Bit idx of the left-justified stream (0..2*SLOT_W-1) for the given frame {left, right}.
    function automatic logic lj_bit(input logic [FW-1:0] fr, input int idx);
        logic [DATA_W-1:0] smp;
        logic [DATA_W-1:0] mask;
        int                s;
        smp = (idx >= SLOT_W) ? fr[DATA_W-1:0] : fr[FW-1:DATA_W];
        s   = idx % SLOT_W;
        if (s < DATA_W) begin
            mask = DATA_W'(1) << (DATA_W - 1 - s);
            return |(smp & mask);
        end
        return 1'b0;
    endfunction

    assign head = mem[rd_ptr_q];
    assign push = in_valid_i && in_ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                frame_d = '0;
                if (en_i) state_d = RUN;
            end
            default: begin
                if (!en_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    frame_d = '0;
                end else if (cnt_q == CW'(F - 1)) begin
                    cnt_d = '0;
                    load  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase

        pop         = load && (level_q != '0);
        underrun_ev = load && (level_q == '0);
        if (pop)
            frame_d = head;
        else if (underrun_ev)
            frame_d = (HOLD_LAST != 0) ? frame_q : '0;

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop)
            level_d = level_q + LW'(1);
        else if (!push && pop)
            level_d = level_q - LW'(1);
        in_ready_d = (level_d < LW'(FIFO_DEPTH));

        // Clear has priority over an underrun arriving in the same cycle.
        underrun_d = underrun_q;
        ucnt_d     = ucnt_q;
        if (clr_underrun_i) begin
            underrun_d = 1'b0;
            ucnt_d     = '0;
        end else if (underrun_ev) begin
            underrun_d = 1'b1;
            if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
        end

        // Pins are registered from the next count so they line up with cnt_q.
        c      = int'(cnt_d);
        b      = c / D;
        mclk_d = 1'b0;
        sck_d  = 1'b0;
        lrck_d = 1'b0;
        sdin_d = 1'b0;
        if (state_d == RUN) begin
            mclk_d = (c % MCLK_DIV) >= (MCLK_DIV / 2);
            sck_d  = (c % D) >= (D / 2);
            lrck_d = (b >= SLOT_W);
            sdin_d = sdin_q;
            if ((c % D) == 0) begin
                if (LJ_MODE != 0)
                    sdin_d = lj_bit(frame_d, b);
                else if (b == 0)
                    sdin_d = lj_bit(frame_q, 2 * SLOT_W - 1);
                else
                    sdin_d = lj_bit(frame_d, b - 1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= {in_left_i, in_right_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            frame_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            in_ready_q <= 1'b0;
            data_rd_q  <= 1'b0;
            underrun_q <= 1'b0;
            ucnt_q     <= '0;
            mclk_q     <= 1'b0;
            sck_q      <= 1'b0;
            lrck_q     <= 1'b0;
            sdin_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            frame_q    <= frame_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            in_ready_q <= in_ready_d;
            data_rd_q  <= pop;
            underrun_q <= underrun_d;
            ucnt_q     <= ucnt_d;
            mclk_q     <= mclk_d;
            sck_q      <= sck_d;
            lrck_q     <= lrck_d;
            sdin_q     <= sdin_d;
        end
    end

    assign in_ready_o     = in_ready_q;
    assign data_rd_o      = data_rd_q;
    assign fifo_level_o   = level_q;
    assign underrun_o     = underrun_q;
    assign underrun_cnt_o = ucnt_q;
    assign mclk_o         = mclk_q;
    assign sck_o          = sck_q;
    assign lrck_o         = lrck_q;
    assign sdin_o         = sdin_q;
endmodule

// File: tb/tb_pmodi2s_tx_fifo.sv
// Directed bench: default I2S instance plus a small left-justified HOLD_LAST instance.
module tb_pmodi2s_tx_fifo;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en0, en1, valid0, valid1, clr;
    logic [23:0] in_l, in_r;

    logic        rdy0, drd0, und0, mclk0, sck0, lrck0, sdin0;
    logic [3:0]  lvl0;
    logic [15:0] ucnt0;
    logic        rdy1, drd1, und1, mclk1, sck1, lrck1, sdin1;
    logic [2:0]  lvl1;
    logic [15:0] ucnt1;

    pmodi2s_tx_fifo dut0 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en0), .in_valid_i(valid0), .in_ready_o(rdy0),
        .in_left_i(in_l), .in_right_i(in_r), .data_rd_o(drd0), .fifo_level_o(lvl0),
        .underrun_o(und0), .underrun_cnt_o(ucnt0), .clr_underrun_i(clr),
        .mclk_o(mclk0), .sck_o(sck0), .lrck_o(lrck0), .sdin_o(sdin0)
    );

    pmodi2s_tx_fifo #(
        .DATA_W(24), .SLOT_W(24), .MCLK_DIV(2), .SCK_RATIO(1), .FIFO_DEPTH(4),
        .LJ_MODE(1), .HOLD_LAST(1)
    ) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en1), .in_valid_i(valid1), .in_ready_o(rdy1),
        .in_left_i(in_l), .in_right_i(in_r), .data_rd_o(drd1), .fifo_level_o(lvl1),
        .underrun_o(und1), .underrun_cnt_o(ucnt1), .clr_underrun_i(clr),
        .mclk_o(mclk1), .sck_o(sck1), .lrck_o(lrck1), .sdin_o(sdin1)
    );

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic [63:0] exp;
    } vec0_t;
    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic [47:0] exp;
    } vec1_t;

    vec0_t tab0[8];
    vec1_t tab1[3];
    int n_cmp = 0;
    int n_bad = 0;
    int nrd0 = 0;
    int nrd1 = 0;

    always @(negedge clk) begin
        if (drd0) nrd0++;
        if (drd1) nrd1++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic push0(input logic [23:0] l, input logic [23:0] r);
        in_l = l; in_r = r; valid0 = 1'b1;
        @(negedge clk);
        valid0 = 1'b0;
    endtask

    task automatic push1(input logic [23:0] l, input logic [23:0] r);
        in_l = l; in_r = r; valid1 = 1'b1;
        @(negedge clk);
        valid1 = 1'b0;
    endtask

    // Entered at the negedge where cnt==0; leaves at cnt==0 of the next frame.
    task automatic capture0(output logic [63:0] bits, output logic [63:0] lr);
        for (int i = 0; i < 64; i++) begin
            repeat (8) @(negedge clk);
            bits[63-i] = sdin0;
            lr[63-i]   = lrck0;
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic capture1(output logic [47:0] bits, output logic [47:0] lr);
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            bits[47-i] = sdin1;
            lr[47-i]   = lrck1;
            @(negedge clk);
        end
    endtask

    function automatic logic pin0(input int sel);
        case (sel)
            0:       return mclk0;
            1:       return sck0;
            default: return lrck0;
        endcase
    endfunction

    task automatic measure0(input int sel, output int per);
        logic prev, cur;
        int   first;
        per   = -1;
        first = -1;
        prev  = pin0(sel);
        for (int i = 0; i < 3000 && per < 0; i++) begin
            @(negedge clk);
            cur = pin0(sel);
            if (!prev && cur) begin
                if (first < 0) first = i;
                else per = i - first;
            end
            prev = cur;
        end
    endtask

    // Stops at the negedge where lrck has just fallen (cnt==0).
    task automatic sync0(output logic found);
        logic prev;
        found = 1'b0;
        prev  = lrck0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (prev && !lrck0) found = 1'b1;
            prev = lrck0;
        end
    endtask

    initial begin
        logic [63:0] bits, lr;
        logic [47:0] bits1, lr1;
        int          per, base;
        logic        found;

        tab0[0] = '{24'hFFFFFF, 24'h000000, 64'h7FFFFF80_00000000};
        tab0[1] = '{24'h800001, 24'h000000, 64'h40000080_00000000};
        tab0[2] = '{24'h000000, 24'hFFFFFF, 64'h00000000_7FFFFF80};
        tab0[3] = '{24'hA5A5A5, 24'h5A5A5A, 64'h52D2D280_2D2D2D00};
        tab0[4] = '{24'h123456, 24'hFEDCBA, 64'h091A2B00_7F6E5D00};
        tab0[5] = '{24'h000001, 24'h800000, 64'h00000080_40000000};
        tab0[6] = '{24'h7FFFFF, 24'h000001, 64'h3FFFFF80_00000080};
        tab0[7] = '{24'hC00003, 24'h3FFFFC, 64'h60000180_1FFFFE00};
        tab1[0] = '{24'h800001, 24'h000000, 48'h800001_000000};
        tab1[1] = '{24'hA5A5A5, 24'h5A5A5A, 48'hA5A5A5_5A5A5A};
        tab1[2] = '{24'h0F0F0F, 24'hF00001, 48'h0F0F0F_F00001};

        rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0; valid0 = 1'b0; valid1 = 1'b0; clr = 1'b0;
        in_l = '0; in_r = '0;
        repeat (3) @(negedge clk);
        check("rst_pins0", 64'({mclk0, sck0, lrck0, sdin0, drd0, und0}), 64'd0);
        check("rst_ready0", 64'(rdy0), 64'd0);
        check("rst_level0", 64'(lvl0), 64'd0);
        check("rst_ucnt0", 64'(ucnt0), 64'd0);
        check("rst_pins1", 64'({mclk1, sck1, lrck1, sdin1, drd1, und1, rdy1, lvl1}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready0_after_rst", 64'(rdy0), 64'd1);
        check("ready1_after_rst", 64'(rdy1), 64'd1);

        // Left-justified, HOLD_LAST=1 instance.
        for (int i = 0; i < 3; i++) push1(tab1[i].l, tab1[i].r);
        check("lj_level3", 64'(lvl1), 64'd3);
        en1 = 1'b1;
        @(negedge clk);
        capture1(bits1, lr1);
        check("lj_first_zero", 64'(bits1), 64'd0);
        check("lj_lrck", 64'(lr1), 64'h0000_0000_00FF_FFFF);
        for (int i = 0; i < 3; i++) begin
            capture1(bits1, lr1);
            check($sformatf("lj_frame%0d", i), 64'(bits1), 64'(tab1[i].exp));
        end
        #1;
        check("lj_data_rd3", 64'(nrd1), 64'd3);
        check("lj_underrun", 64'(und1), 64'd1);
        check("lj_ucnt1", 64'(ucnt1), 64'd1);
        capture1(bits1, lr1);
        check("lj_hold_last", 64'(bits1), 64'(tab1[2].exp));
        en1 = 1'b0;
        @(negedge clk);

        // Default I2S instance: fill with no clocks running.
        for (int i = 0; i < 8; i++) push0(tab0[i].l, tab0[i].r);
        check("fill_level8", 64'(lvl0), 64'd8);
        check("fill_ready0", 64'(rdy0), 64'd0);
        push0(24'h111111, 24'h222222);
        check("ninth_rejected", 64'(lvl0), 64'd8);

        base = nrd0;
        en0 = 1'b1;
        @(negedge clk);
        capture0(bits, lr);
        check("i2s_first_zero", bits, 64'd0);
        check("i2s_lrck", lr, 64'h00000000_FFFFFFFF);
        #1;
        check("first_pop", 64'(nrd0 - base), 64'd1);
        for (int i = 0; i < 8; i++) begin
            capture0(bits, lr);
            check($sformatf("i2s_frame%0d", i), bits, tab0[i].exp);
        end
        #1;
        check("pops8", 64'(nrd0 - base), 64'd8);
        check("underrun_set", 64'(und0), 64'd1);
        check("ucnt_1", 64'(ucnt0), 64'd1);
        check("level_empty", 64'(lvl0), 64'd0);
        capture0(bits, lr);
        check("underrun_zero_frame", bits, 64'd0);
        check("ucnt_2", 64'(ucnt0), 64'd2);

        measure0(0, per);
        check("mclk_period", 64'(per), 64'd4);
        measure0(1, per);
        check("sck_period", 64'(per), 64'd16);
        measure0(2, per);
        check("lrck_period", 64'(per), 64'd1024);

        // Clear asserted in the very cycle of a new underrun load.
        sync0(found);
        check("sync_found", 64'(found), 64'd1);
        repeat (1023) @(negedge clk);
        check("underrun_before_clr", 64'(und0), 64'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_wins_flag", 64'(und0), 64'd0);
        check("clr_wins_cnt", 64'(ucnt0), 64'd0);

        // Stop mid right slot, restart: zero frame, then the untouched FIFO head.
        push0(tab0[0].l, tab0[0].r);
        push0(tab0[1].l, tab0[1].r);
        check("level2", 64'(lvl0), 64'd2);
        repeat (1022) @(negedge clk);
        #1;
        check("pop_after_clr", 64'(nrd0 - base), 64'd9);
        repeat (700) @(negedge clk);
        check("mid_right_lrck", 64'(lrck0), 64'd1);
        en0 = 1'b0;
        @(negedge clk);
        check("stop_pins", 64'({mclk0, sck0, lrck0, sdin0}), 64'd0);
        check("stop_level_kept", 64'(lvl0), 64'd1);
        repeat (5) @(negedge clk);
        en0 = 1'b1;
        @(negedge clk);
        capture0(bits, lr);
        check("restart_zero", bits, 64'd0);
        capture0(bits, lr);
        check("restart_head", bits, tab0[1].exp);

        // Asynchronous reset in the middle of a frame.
        push0(tab0[3].l, tab0[3].r);
        check("pre_rst_level", 64'(lvl0), 64'd1);
        check("pre_rst_ucnt", 64'(ucnt0), 64'd1);
        repeat (300) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pins", 64'({mclk0, sck0, lrck0, sdin0, drd0, und0, rdy0}), 64'd0);
        check("async_rst_level", 64'(lvl0), 64'd0);
        check("async_rst_ucnt", 64'(ucnt0), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
